diff_decoder: RTL and testbench
===============================

DIFF_DECODER -- requirements
Module: diff_decoder

Interface
REQ-001 Parameter BLOCK_BYTES, default 512, bytes per block; SHALL be at least 2.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 s_axis_valid  input  1  input byte valid.
REQ-005 s_axis_ready  output  1  input byte accepted when valid && ready.
REQ-006 s_axis_data  input  8  differentially encoded byte, MSB is first in time.
REQ-007 s_axis_last  input  1  last byte of block.
REQ-008 s_axis_sop  input  1  first byte of block.
REQ-009 s_axis_is_parity  input  1  sideband, passed through unchanged.
REQ-010 m_axis_valid / m_axis_ready / m_axis_data[7:0] / m_axis_last / m_axis_sop / m_axis_is_parity  output/input/output...  decoded stream, same meanings as the s_axis signals.
REQ-011 err_sop  output  1  one-cycle pulse on a sop framing error.
REQ-012 err_len  output  1  one-cycle pulse on a block-length error.

Function
REQ-013 Decode rule per accepted byte y with history p: x[7]=y[7]^p; x[k]=y[k]^y[k+1] for k=6..0.
REQ-014 p SHALL be 0 when s_axis_sop=1; otherwise p SHALL be the stored y[0] of the previous accepted byte.
REQ-015 The history register SHALL load input bit y[0], not output bit x[0], on every accepted byte.
REQ-016 The output path SHALL be registered through a 2-entry skid buffer: latency 1 cycle from accept to m_axis_valid; 1 byte/cycle sustained throughput.
REQ-017 s_axis_ready SHALL be driven from a register: high while the skid buffer holds fewer than 2 entries, with no combinational path from m_axis_ready.
REQ-018 Output bytes SHALL stay in order; m_axis_* SHALL hold stable while m_axis_valid && !m_axis_ready.
REQ-019 last, sop and is_parity SHALL travel with their byte unchanged.
REQ-020 Framing FSM states: IDLE (expecting sop) and IN_BLOCK; a byte counter cnt counts 0..BLOCK_BYTES-1 and holds the index of the next byte.
REQ-021 IDLE, byte accepted with sop: cnt:=1, go to IN_BLOCK.
REQ-022 IDLE, byte accepted without sop: pulse err_sop; decode with p=0; cnt:=1; go to IN_BLOCK.
REQ-023 IN_BLOCK, byte accepted with sop: pulse err_sop; restart the block with p=0, cnt:=1.
REQ-024 IN_BLOCK, last accepted with cnt==BLOCK_BYTES-1: go to IDLE with no error.
REQ-025 Last accepted with cnt!=BLOCK_BYTES-1, or cnt==BLOCK_BYTES-1 accepted without last: pulse err_len; go to IDLE.
REQ-026 A byte with both sop and last in IDLE SHALL pulse err_len only, then go to IDLE.
REQ-027 Error pulses SHALL be registered and asserted in the cycle after the offending accept.
REQ-028 The FSM, cnt and history SHALL advance only on s_axis_valid && s_axis_ready; stalls SHALL alter nothing.

Reset
REQ-029 On reset, m_axis_valid, err_sop, err_len, history, cnt and the buffer occupancy SHALL be 0, and the FSM SHALL be in IDLE.
REQ-030 s_axis_ready SHALL be 0 during reset and 1 in the first cycle after release.
REQ-031 Reset mid-block SHALL discard buffered bytes; the next block SHALL decode from p=0.

Structure
REQ-032 BLOCK_BYTES default and the framing FSM state enum SHALL live in the shared package mpu_pkg.
REQ-033 The skid buffer SHALL be a separate sub-module, axis_skid_buffer, parameterised on payload width (11 bits: data+last+sop+is_parity).
REQ-034 Decode logic and the FSM SHALL stay in diff_decoder.

Verification
REQ-035 Single sop byte 0xFF -> output 0x80, no error; next byte 0x00 -> 0x80 (history=1).
REQ-036 Sop byte 0xAA -> 0xFF; 512 random bytes encoded by diff_encoder then decoded -> identical to source, last on byte 511, no errors.
REQ-037 Random m_axis_ready (50%) and random s_axis_valid over 4 blocks -> no loss, duplication or reordering; throughput 1 byte/cycle when ready stays high.
REQ-038 First byte without sop -> err_sop one cycle after accept, decoded with p=0; sop at byte 100 -> err_sop, history reset.
REQ-039 last at byte 10 -> err_len, FSM to IDLE; 512 bytes without last -> err_len after byte 511.
REQ-040 rst_n asserted at byte 200 with 2 bytes buffered -> m_axis_valid=0 immediately; next block decodes correctly with p=0.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU stream blocks.
//   BLOCK_BYTES_DEFAULT : default number of bytes in one framed block
//   SKID_PAYLOAD_W      : width of the byte payload carried through the skid
//                         buffer (data[7:0] + last + sop + is_parity)
//   frame_state_e       : block framing state (waiting for sop / inside a block)
package mpu_pkg;

  localparam int unsigned BLOCK_BYTES_DEFAULT = 512;
  localparam int unsigned SKID_PAYLOAD_W      = 11;

  typedef enum logic {
    FRM_IDLE     = 1'b0,
    FRM_IN_BLOCK = 1'b1
  } frame_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer for a valid/ready stream.
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_valid/s_ready   : upstream handshake; s_ready is a flop output
//   s_data[DATA_W-1:0]: upstream payload
//   m_valid/m_ready   : downstream handshake
//   m_data[DATA_W-1:0]: downstream payload, held while m_valid && !m_ready
// An accepted word appears on m_* one cycle later. s_ready is computed from
// the next occupancy, so it never depends combinationally on m_ready.
module axis_skid_buffer
  import mpu_pkg::*;
#(
  parameter int unsigned DATA_W = SKID_PAYLOAD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
);

  logic [1:0]        occ_q, occ_d;
  logic              s_ready_q, s_ready_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              push, pop;

  assign push = s_valid && s_ready_q;
  assign pop  = (occ_q != 2'd0) && m_ready;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    case (occ_q)
      2'd0: begin
        if (push) begin
          head_d = s_data;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = s_data;
        end else if (push) begin
          skid_d = s_data;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d  = 2'd0;
        end
      end
      2'd2: begin
        // s_ready is low here, so only a pop can happen
        if (pop) begin
          head_d = skid_q;
          occ_d  = 2'd1;
        end
      end
      default: occ_d = 2'd0;
    endcase
    s_ready_d = (occ_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q     <= 2'd0;
      s_ready_q <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      s_ready_q <= s_ready_d;
    end
  end

  // payload storage carries no reset; occupancy alone qualifies it
  always_ff @(posedge clk) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end

  assign s_ready = s_ready_q;
  assign m_valid = (occ_q != 2'd0);
  assign m_data  = head_q;

endmodule

// File: rtl/diff_decoder.sv
// Differential byte-stream decoder with block framing checks.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   s_axis_valid/ready/data    : encoded byte stream, data MSB first in time
//   s_axis_last/sop/is_parity  : block end, block start, parity sideband
//   m_axis_*                   : decoded stream, same meanings as s_axis_*
//   err_sop                    : pulse, byte framed against the sop rules
//   err_len                    : pulse, block ended at the wrong length
// Each bit is XORed with the bit transmitted before it; the first bit of a
// block is XORed with 0. The history flop holds the last received (encoded)
// bit, so it loads y[0], not the decoded x[0].
module diff_decoder
  import mpu_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES = BLOCK_BYTES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_axis_valid,
  output logic       s_axis_ready,
  input  logic [7:0] s_axis_data,
  input  logic       s_axis_last,
  input  logic       s_axis_sop,
  input  logic       s_axis_is_parity,
  output logic       m_axis_valid,
  input  logic       m_axis_ready,
  output logic [7:0] m_axis_data,
  output logic       m_axis_last,
  output logic       m_axis_sop,
  output logic       m_axis_is_parity,
  output logic       err_sop,
  output logic       err_len
);

  localparam int unsigned      CNT_W    = $clog2(BLOCK_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_BYTES - 1);

  function automatic logic [7:0] diff_decode(input logic [7:0] y, input logic p);
    return {y[7] ^ p, y[6:0] ^ y[7:1]};
  endfunction

  frame_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hist_q, hist_d;
  logic             err_sop_q, err_sop_d;
  logic             err_len_q, err_len_d;

  logic             accept;
  logic             blk_start;
  logic [CNT_W-1:0] idx;
  logic             p;
  logic [7:0]       dec_data;
  logic             skid_ready;
  logic [SKID_PAYLOAD_W-1:0] skid_in, skid_out;

  assign accept    = s_axis_valid && skid_ready;
  // a byte opens a new block on sop, or whenever we were not inside one
  assign blk_start = s_axis_sop || (state_q == FRM_IDLE);
  assign idx       = blk_start ? '0 : cnt_q;
  assign p         = blk_start ? 1'b0 : hist_q;
  assign dec_data  = diff_decode(s_axis_data, p);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hist_d    = hist_q;
    err_sop_d = 1'b0;
    err_len_d = 1'b0;
    if (accept) begin
      hist_d    = s_axis_data[0];
      err_sop_d = ((state_q == FRM_IDLE) && !s_axis_sop) ||
                  ((state_q == FRM_IN_BLOCK) && s_axis_sop);
      if (s_axis_last || (idx == LAST_IDX)) begin
        // only last on the final index closes a block cleanly
        err_len_d = !(s_axis_last && (idx == LAST_IDX));
        state_d   = FRM_IDLE;
        cnt_d     = '0;
      end else begin
        state_d   = FRM_IN_BLOCK;
        cnt_d     = idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FRM_IDLE;
      cnt_q     <= '0;
      hist_q    <= 1'b0;
      err_sop_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hist_q    <= hist_d;
      err_sop_q <= err_sop_d;
      err_len_q <= err_len_d;
    end
  end

  assign skid_in = {dec_data, s_axis_last, s_axis_sop, s_axis_is_parity};

  axis_skid_buffer #(
    .DATA_W (SKID_PAYLOAD_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_axis_valid),
    .s_ready (skid_ready),
    .s_data  (skid_in),
    .m_valid (m_axis_valid),
    .m_ready (m_axis_ready),
    .m_data  (skid_out)
  );

  assign s_axis_ready     = skid_ready;
  assign m_axis_data      = skid_out[10:3];
  assign m_axis_last      = skid_out[2];
  assign m_axis_sop       = skid_out[1];
  assign m_axis_is_parity = skid_out[0];
  assign err_sop          = err_sop_q;
  assign err_len          = err_len_q;

endmodule

// File: tb/tb_diff_decoder.sv
module tb_diff_decoder;

  localparam int BB = 512;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       s_sop = 1'b0;
  logic       s_par = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_last, m_sop, m_par;
  logic       err_sop, err_len;

  always #5 clk = ~clk;

  diff_decoder #(.BLOCK_BYTES(BB)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_axis_valid     (s_valid),
    .s_axis_ready     (s_ready),
    .s_axis_data      (s_data),
    .s_axis_last      (s_last),
    .s_axis_sop       (s_sop),
    .s_axis_is_parity (s_par),
    .m_axis_valid     (m_valid),
    .m_axis_ready     (m_ready),
    .m_axis_data      (m_data),
    .m_axis_last      (m_last),
    .m_axis_sop       (m_sop),
    .m_axis_is_parity (m_par),
    .err_sop          (err_sop),
    .err_len          (err_len)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       sop;
    logic       par;
  } beat_t;

  beat_t      tx_q[$];
  beat_t      exp_q[$];
  beat_t      got_q[$];
  logic [1:0] exp_err_q[$];
  logic [1:0] err_got_q[$];

  int total = 0;
  int bad = 0;
  int stray = 0;
  int stalls = 0;
  int ready_mode = 0;   // 0: always ready, 1: 50% random, 2: never ready
  int cyc = 0;
  int first_out = -1;
  int last_out = -1;
  bit acc_prev = 1'b0;

  // downstream ready pattern
  always @(posedge clk) begin
    cyc++;
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(1));
      default: m_ready = 1'b0;
    endcase
  end

  // monitor: collects output beats and the error flags seen one cycle after each accept
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_prev = 1'b0;
    end else begin
      if (acc_prev) err_got_q.push_back({err_sop, err_len});
      else if (err_sop || err_len) stray++;
      acc_prev = s_valid && s_ready;
      if (m_valid && m_ready) begin
        got_q.push_back('{d: m_data, last: m_last, sop: m_sop, par: m_par});
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
    end
  end

  task automatic clear_all();
    tx_q.delete(); exp_q.delete(); got_q.delete();
    exp_err_q.delete(); err_got_q.delete();
    stray = 0; stalls = 0; first_out = -1; last_out = -1;
  endtask

  task automatic add_beat(input logic [7:0] d, input logic sop, input logic last);
    tx_q.push_back('{d: d, last: last, sop: sop, par: 1'($urandom_range(1))});
  endtask

  // reference: serial bit stream, each bit XOR the bit received before it
  function automatic void run_model();
    bit         in_blk = 0;
    int         nidx = 0;
    logic       prev = 1'b0;
    exp_q.delete(); exp_err_q.delete();
    for (int i = 0; i < tx_q.size(); i++) begin
      beat_t      b = tx_q[i];
      bit         start = b.sop || !in_blk;
      int         pos = start ? 0 : nidx;
      logic       pb = start ? 1'b0 : prev;
      logic [7:0] o;
      logic       es, el;
      for (int k = 7; k >= 0; k--) begin
        o[k] = b.d[k] ^ pb;
        pb   = b.d[k];
      end
      prev = pb;
      es = (in_blk && b.sop) || (!in_blk && !b.sop);
      el = 1'b0;
      if (b.last) begin
        el = (pos != BB - 1); in_blk = 0;
      end else if (pos == BB - 1) begin
        el = 1'b1; in_blk = 0;
      end else begin
        in_blk = 1; nidx = pos + 1;
      end
      exp_q.push_back('{d: o, last: b.last, sop: b.sop, par: b.par});
      exp_err_q.push_back({es, el});
    end
  endfunction

  task automatic drive_list(input int gap_pct);
    for (int i = 0; i < tx_q.size(); i++) begin
      int t = 0;
      while (int'($urandom_range(99)) < gap_pct) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = tx_q[i].d;
      s_last  = tx_q[i].last;
      s_sop   = tx_q[i].sop;
      s_par   = tx_q[i].par;
      while (1) begin
        @(negedge clk);
        if (s_ready) break;
        stalls++; t++;
        if (t > 2000) begin
          total++; bad++;
          $display("FAIL accept_timeout beat %0d: s_ready stayed %b, required 1", i, s_ready);
          s_valid = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (got_q.size() < tx_q.size() && t < 20000) begin
      @(posedge clk); t++;
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (got_q.size() != tx_q.size()) begin
      bad++;
      $display("FAIL drain_count: got %0d beats, required %0d", got_q.size(), tx_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    total++; if (err_sop !== 1'b0) begin bad++; $display("FAIL rst_err_sop: got %b want 0", err_sop); end
    total++; if (err_len !== 1'b0) begin bad++; $display("FAIL rst_err_len: got %b want 0", err_len); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rel_s_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_known();
    clear_all();
    add_beat(8'hFF, 1'b1, 1'b0);
    add_beat(8'h00, 1'b0, 1'b0);
    add_beat(8'hAA, 1'b1, 1'b1);
    drive_list(0);
    wait_drain();
    if (got_q.size() >= 3) begin
      total++; if (got_q[0].d !== 8'h80) begin bad++; $display("FAIL known_ff: got %h want 80", got_q[0].d); end
      total++; if (got_q[1].d !== 8'h80) begin bad++; $display("FAIL known_00_hist1: got %h want 80", got_q[1].d); end
      total++; if (got_q[2].d !== 8'hFF) begin bad++; $display("FAIL known_aa: got %h want ff", got_q[2].d); end
    end
    total++; if (err_got_q.size() >= 1 && err_got_q[0] !== 2'b00) begin bad++; $display("FAIL known_ff_err: got %b want 00", err_got_q[0]); end
    run_model();
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || i >= err_got_q.size()) begin bad++; $display("FAIL known_missing beat %0d", i); end
      else if ({got_q[i], err_got_q[i]} !== {exp_q[i], exp_err_q[i]}) begin
        bad++; $display("FAIL known beat %0d: got %h/%b want %h/%b", i, got_q[i], err_got_q[i], exp_q[i], exp_err_q[i]);
      end
    end
  endtask

  task automatic test_roundtrip();
    logic [7:0] src[BB];
    logic       p = 1'b0;
    clear_all();
    ready_mode = 0;
    for (int i = 0; i < BB; i++) begin
      logic [7:0] y;
      src[i] = 8'($urandom);
      for (int k = 7; k >= 0; k--) begin
        y[k] = src[i][k] ^ p;
        p    = y[k];
      end
      add_beat(y, i == 0, i == BB - 1);
    end
    drive_list(0);
    wait_drain();
    total++; if (stalls != 0) begin bad++; $display("FAIL rt_stalls: got %0d want 0", stalls); end
    total++; if (last_out - first_out != BB - 1) begin bad++; $display("FAIL rt_throughput: span %0d want %0d", last_out - first_out, BB - 1); end
    total++; if (stray != 0) begin bad++; $display("FAIL rt_stray_err: got %0d want 0", stray); end
    for (int i = 0; i < BB; i++) begin
      total++;
      if (i >= got_q.size() || i >= err_got_q.size()) begin bad++; $display("FAIL rt_missing beat %0d", i); end
      else if ({got_q[i].d, got_q[i].last, err_got_q[i]} !== {src[i], 1'(i == BB - 1), 2'b00}) begin
        bad++; $display("FAIL rt beat %0d: got %h last %b err %b want %h last %b err 00", i, got_q[i].d, got_q[i].last, err_got_q[i], src[i], i == BB - 1);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_all();
    ready_mode = 1;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < BB; i++) add_beat(8'($urandom), i == 0, i == BB - 1);
    drive_list(30);
    wait_drain();
    ready_mode = 0;
    total++; if (stray != 0) begin bad++; $display("FAIL bp_stray_err: got %0d want 0", stray); end
    run_model();
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || i >= err_got_q.size()) begin bad++; $display("FAIL bp_missing beat %0d", i); end
      else if ({got_q[i], err_got_q[i]} !== {exp_q[i], exp_err_q[i]}) begin
        bad++; $display("FAIL bp beat %0d: got %h/%b want %h/%b", i, got_q[i], err_got_q[i], exp_q[i], exp_err_q[i]);
      end
    end
  endtask

  task automatic test_sop_errors();
    clear_all();
    ready_mode = 1;
    for (int i = 0; i < 150; i++) begin
      logic [7:0] d = 8'($urandom);
      if (i == 0 || i == 100) d = 8'hFF;
      if (i == 99) d = 8'h01;   // leaves history = 1 ahead of the mid-block sop
      add_beat(d, i == 100, i == 149);
    end
    drive_list(20);
    wait_drain();
    ready_mode = 0;
    if (got_q.size() > 100 && err_got_q.size() > 100) begin
      total++; if (err_got_q[0][1] !== 1'b1) begin bad++; $display("FAIL sop_first_err: got %b want 1", err_got_q[0][1]); end
      total++; if (got_q[0].d !== 8'h80) begin bad++; $display("FAIL sop_first_p0: got %h want 80", got_q[0].d); end
      total++; if (err_got_q[100][1] !== 1'b1) begin bad++; $display("FAIL sop_mid_err: got %b want 1", err_got_q[100][1]); end
      total++; if (got_q[100].d !== 8'h80) begin bad++; $display("FAIL sop_mid_hist: got %h want 80", got_q[100].d); end
    end
    run_model();
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || i >= err_got_q.size()) begin bad++; $display("FAIL sop_missing beat %0d", i); end
      else if ({got_q[i], err_got_q[i]} !== {exp_q[i], exp_err_q[i]}) begin
        bad++; $display("FAIL sop beat %0d: got %h/%b want %h/%b", i, got_q[i], err_got_q[i], exp_q[i], exp_err_q[i]);
      end
    end
  endtask

  task automatic test_len_errors();
    clear_all();
    for (int i = 0; i < 11; i++) add_beat(8'($urandom), i == 0, i == 10);
    for (int i = 0; i < BB; i++) add_beat(8'($urandom), i == 0, 1'b0);
    drive_list(10);
    wait_drain();
    if (err_got_q.size() > 11 + BB - 1) begin
      total++; if (err_got_q[10] !== 2'b01) begin bad++; $display("FAIL len_short: got %b want 01", err_got_q[10]); end
      total++; if (err_got_q[11 + BB - 2] !== 2'b00) begin bad++; $display("FAIL len_510: got %b want 00", err_got_q[11 + BB - 2]); end
      total++; if (err_got_q[11 + BB - 1] !== 2'b01) begin bad++; $display("FAIL len_nolast: got %b want 01", err_got_q[11 + BB - 1]); end
    end
    run_model();
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || i >= err_got_q.size()) begin bad++; $display("FAIL len_missing beat %0d", i); end
      else if ({got_q[i], err_got_q[i]} !== {exp_q[i], exp_err_q[i]}) begin
        bad++; $display("FAIL len beat %0d: got %h/%b want %h/%b", i, got_q[i], err_got_q[i], exp_q[i], exp_err_q[i]);
      end
    end
  endtask

  task automatic test_reset_midblock();
    clear_all();
    ready_mode = 0;
    for (int i = 0; i < 198; i++) add_beat(8'($urandom), i == 0, 1'b0);
    drive_list(0);
    wait_drain();
    ready_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    tx_q.delete();
    add_beat(8'h5C, 1'b0, 1'b0);
    add_beat(8'h01, 1'b0, 1'b0);
    drive_list(0);
    total++; if (m_valid !== 1'b1 || s_ready !== 1'b0) begin bad++; $display("FAIL mid_full: m_valid %b s_ready %b want 1 0", m_valid, s_ready); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", m_valid); end
    repeat (2) @(posedge clk);
    #1;
    ready_mode = 0;
    clear_all();
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin bad++; $display("FAIL mid_release: m_valid %b s_ready %b want 0 1", m_valid, s_ready); end
    add_beat(8'hFF, 1'b1, 1'b0);
    for (int i = 1; i < 20; i++) add_beat(8'($urandom), 1'b0, i == 19);
    drive_list(0);
    wait_drain();
    total++; if (got_q.size() > 0 && got_q[0].d !== 8'h80) begin bad++; $display("FAIL mid_first: got %h want 80", got_q[0].d); end
    run_model();
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || i >= err_got_q.size()) begin bad++; $display("FAIL mid_missing beat %0d", i); end
      else if ({got_q[i], err_got_q[i]} !== {exp_q[i], exp_err_q[i]}) begin
        bad++; $display("FAIL mid beat %0d: got %h/%b want %h/%b", i, got_q[i], err_got_q[i], exp_q[i], exp_err_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_roundtrip();
    test_backpressure();
    test_sop_errors();
    test_len_errors();
    test_reset_midblock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
